// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or branch flush, and a saturating stall-cycle counter.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_SignExt,
    input  logic              ID_RegWrite,
    input  logic              ID_MemToReg,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic [3:0]        ID_ALUOp,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic [DATA_W-1:0] EX_ReadData1,
    output logic [DATA_W-1:0] EX_ReadData2,
    output logic [DATA_W-1:0] EX_SignExt,
    output logic              EX_RegWrite,
    output logic              EX_MemToReg,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_ALUSrc,
    output logic              EX_RegDst,
    output logic [3:0]        EX_ALUOp,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic [CNT_W-1:0]  StallCount
);

    logic hazard;
    logic stall;
    logic bubble;

    // Flush wins over a hazard: the PC must move to the branch target, but the
    // instruction entering EX is still squashed.
    always_comb begin
        hazard    = EX_MemRead && (EX_Rt != 5'd0) &&
                    ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));
        stall     = hazard && !Flush;
        bubble    = hazard || Flush;
        PCWrite   = !stall;
        IFIDWrite = !stall;
    end

    // Operand data is loaded even during a bubble; it is don't-care downstream.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            EX_ReadData1 <= '0;
            EX_ReadData2 <= '0;
            EX_SignExt   <= '0;
        end else begin
            EX_ReadData1 <= ID_ReadData1;
            EX_ReadData2 <= ID_ReadData2;
            EX_SignExt   <= ID_SignExt;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            EX_Rs       <= '0;
            EX_Rt       <= '0;
            EX_Rd       <= '0;
            EX_RegWrite <= 1'b0;
            EX_MemToReg <= 1'b0;
            EX_MemRead  <= 1'b0;
            EX_MemWrite <= 1'b0;
            EX_ALUSrc   <= 1'b0;
            EX_RegDst   <= 1'b0;
            EX_ALUOp    <= '0;
        end else if (bubble) begin
            EX_Rs       <= '0;
            EX_Rt       <= '0;
            EX_Rd       <= '0;
            EX_RegWrite <= 1'b0;
            EX_MemToReg <= 1'b0;
            EX_MemRead  <= 1'b0;
            EX_MemWrite <= 1'b0;
            EX_ALUSrc   <= 1'b0;
            EX_RegDst   <= 1'b0;
            EX_ALUOp    <= '0;
        end else begin
            EX_Rs       <= ID_Rs;
            EX_Rt       <= ID_Rt;
            EX_Rd       <= ID_Rd;
            EX_RegWrite <= ID_RegWrite;
            EX_MemToReg <= ID_MemToReg;
            EX_MemRead  <= ID_MemRead;
            EX_MemWrite <= ID_MemWrite;
            EX_ALUSrc   <= ID_ALUSrc;
            EX_RegDst   <= ID_RegDst;
            EX_ALUOp    <= ID_ALUOp;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StallCount <= '0;
        end else if (stall && (StallCount != '1)) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, load-use stall, r0, flush priority,
// non-load dependency, back-to-back loads, reset mid-stall and counter saturation.
module tb_id_ex_stage_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              Clk;
    logic              Rst_n;
    logic              Flush;
    logic [4:0]        ID_Rs, ID_Rt, ID_Rd;
    logic [DATA_W-1:0] ID_ReadData1, ID_ReadData2, ID_SignExt;
    logic              ID_RegWrite, ID_MemToReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst;
    logic [3:0]        ID_ALUOp;
    logic [4:0]        EX_Rs, EX_Rt, EX_Rd;
    logic [DATA_W-1:0] EX_ReadData1, EX_ReadData2, EX_SignExt;
    logic              EX_RegWrite, EX_MemToReg, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst;
    logic [3:0]        EX_ALUOp;
    logic              PCWrite, IFIDWrite;
    logic [CNT_W-1:0]  StallCount;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [CNT_W-1:0] sc_exp = '0;

    id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignExt(ID_SignExt),
        .ID_RegWrite(ID_RegWrite), .ID_MemToReg(ID_MemToReg), .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
        .ID_ALUOp(ID_ALUOp),
        .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
        .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_SignExt(EX_SignExt),
        .EX_RegWrite(EX_RegWrite), .EX_MemToReg(EX_MemToReg), .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst),
        .EX_ALUOp(EX_ALUOp),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .StallCount(StallCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic [3:0] op,
                         input logic [31:0] d1);
        ID_Rs = rs; ID_Rt = rt; ID_Rd = rd;
        ID_RegWrite = rw; ID_MemToReg = mr; ID_MemRead = mr; ID_MemWrite = 1'b0;
        ID_ALUSrc = mr; ID_RegDst = !mr; ID_ALUOp = op;
        ID_ReadData1 = d1; ID_ReadData2 = ~d1; ID_SignExt = {16'h0, d1[15:0]};
    endtask

    task automatic step();
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Flush = 1'b0;
        drive(5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 4'hF, 32'h1234_5678);
        ID_MemWrite = 1'b1; ID_RegDst = 1'b1;
        step(); step();
        n_checks++; if ({EX_Rs, EX_Rt, EX_Rd} !== 15'd0) begin n_fail++; $display("FAIL rst_regs got %h exp 0", {EX_Rs, EX_Rt, EX_Rd}); end
        n_checks++; if ({EX_RegWrite, EX_MemToReg, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst, EX_ALUOp} !== 10'd0) begin n_fail++; $display("FAIL rst_ctrl got %h exp 0", {EX_RegWrite, EX_MemToReg, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst, EX_ALUOp}); end
        n_checks++; if ({EX_ReadData1, EX_ReadData2, EX_SignExt} !== 96'd0) begin n_fail++; $display("FAIL rst_data got %h exp 0", {EX_ReadData1, EX_ReadData2, EX_SignExt}); end
        n_checks++; if (StallCount !== 4'd0) begin n_fail++; $display("FAIL rst_cnt got %h exp 0", StallCount); end
        n_checks++; if ({PCWrite, IFIDWrite} !== 2'b11) begin n_fail++; $display("FAIL rst_pcw got %b exp 11", {PCWrite, IFIDWrite}); end
        @(negedge Clk);
        Rst_n = 1'b1;
        drive(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 4'h0, 32'hDEAD_BEEF);
        step();
        n_checks++; if (EX_Rs !== 5'd3) begin n_fail++; $display("FAIL rel_rs got %0d exp 3", EX_Rs); end
        n_checks++; if (EX_ReadData1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rel_rd1 got %h exp deadbeef", EX_ReadData1); end
    endtask

    task automatic test_load_use();
        @(negedge Clk); drive(5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 4'h0, 32'h0000_0100);
        step();
        @(negedge Clk); drive(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 4'h2, 32'hAAAA_5555);
        #1;
        n_checks++; if ({PCWrite, IFIDWrite} !== 2'b00) begin n_fail++; $display("FAIL lu_stall got %b exp 00", {PCWrite, IFIDWrite}); end
        step(); sc_exp = sc_exp + 4'd1;
        n_checks++; if ({EX_RegWrite, EX_MemRead, EX_MemToReg, EX_ALUSrc, EX_RegDst, EX_ALUOp} !== 9'd0) begin n_fail++; $display("FAIL lu_bub_ctrl got %h exp 0", {EX_RegWrite, EX_MemRead, EX_MemToReg, EX_ALUSrc, EX_RegDst, EX_ALUOp}); end
        n_checks++; if ({EX_Rs, EX_Rt, EX_Rd} !== 15'd0) begin n_fail++; $display("FAIL lu_bub_regs got %h exp 0", {EX_Rs, EX_Rt, EX_Rd}); end
        n_checks++; if (EX_ReadData1 !== 32'hAAAA_5555) begin n_fail++; $display("FAIL lu_bub_data got %h exp aaaa5555", EX_ReadData1); end
        n_checks++; if (StallCount !== sc_exp) begin n_fail++; $display("FAIL lu_cnt got %0d exp %0d", StallCount, sc_exp); end
        n_checks++; if ({PCWrite, IFIDWrite} !== 2'b11) begin n_fail++; $display("FAIL lu_release got %b exp 11", {PCWrite, IFIDWrite}); end
        step();
        n_checks++; if ({EX_Rs, EX_Rt, EX_Rd} !== {5'd5, 5'd6, 5'd7}) begin n_fail++; $display("FAIL lu_held_regs got %h exp %h", {EX_Rs, EX_Rt, EX_Rd}, {5'd5, 5'd6, 5'd7}); end
        n_checks++; if ({EX_RegWrite, EX_ALUOp} !== 5'h12) begin n_fail++; $display("FAIL lu_held_ctrl got %h exp 12", {EX_RegWrite, EX_ALUOp}); end
        n_checks++; if (StallCount !== sc_exp) begin n_fail++; $display("FAIL lu_cnt_hold got %0d exp %0d", StallCount, sc_exp); end
    endtask

    task automatic test_reg_zero();
        @(negedge Clk); drive(5'd2, 5'd0, 5'd0, 1'b1, 1'b1, 4'h0, 32'h0);
        step();
        @(negedge Clk); drive(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 4'h3, 32'h0);
        #1;
        n_checks++; if ({PCWrite, IFIDWrite} !== 2'b11) begin n_fail++; $display("FAIL r0_pcw got %b exp 11", {PCWrite, IFIDWrite}); end
        step();
        n_checks++; if ({EX_RegWrite, EX_Rd, EX_ALUOp} !== {1'b1, 5'd4, 4'h3}) begin n_fail++; $display("FAIL r0_capture got %h exp %h", {EX_RegWrite, EX_Rd, EX_ALUOp}, {1'b1, 5'd4, 4'h3}); end
        n_checks++; if (StallCount !== sc_exp) begin n_fail++; $display("FAIL r0_cnt got %0d exp %0d", StallCount, sc_exp); end
    endtask

    task automatic test_flush();
        @(negedge Clk); drive(5'd1, 5'd8, 5'd0, 1'b1, 1'b1, 4'h0, 32'h0);
        step();
        @(negedge Clk); drive(5'd8, 5'd2, 5'd9, 1'b1, 1'b0, 4'h6, 32'h0); Flush = 1'b1;
        #1;
        n_checks++; if ({PCWrite, IFIDWrite} !== 2'b11) begin n_fail++; $display("FAIL fl_pcw got %b exp 11", {PCWrite, IFIDWrite}); end
        step(); Flush = 1'b0;
        n_checks++; if ({EX_RegWrite, EX_Rs, EX_Rd, EX_ALUOp} !== 15'd0) begin n_fail++; $display("FAIL fl_bubble got %h exp 0", {EX_RegWrite, EX_Rs, EX_Rd, EX_ALUOp}); end
        n_checks++; if (StallCount !== sc_exp) begin n_fail++; $display("FAIL fl_cnt got %0d exp %0d", StallCount, sc_exp); end
    endtask

    task automatic test_non_load();
        @(negedge Clk); drive(5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 4'h1, 32'h0);
        step();
        @(negedge Clk); drive(5'd3, 5'd7, 5'd10, 1'b1, 1'b0, 4'h5, 32'h0);
        #1;
        n_checks++; if ({PCWrite, IFIDWrite} !== 2'b11) begin n_fail++; $display("FAIL nl_pcw got %b exp 11", {PCWrite, IFIDWrite}); end
        step();
        n_checks++; if ({EX_Rs, EX_Rt, EX_ALUOp} !== {5'd3, 5'd7, 4'h5}) begin n_fail++; $display("FAIL nl_capture got %h exp %h", {EX_Rs, EX_Rt, EX_ALUOp}, {5'd3, 5'd7, 4'h5}); end
    endtask

    task automatic test_back_to_back();
        @(negedge Clk); drive(5'd1, 5'd10, 5'd0, 1'b1, 1'b1, 4'h0, 32'h0);
        step();
        @(negedge Clk); drive(5'd10, 5'd11, 5'd0, 1'b1, 1'b1, 4'h0, 32'h0);
        #1;
        n_checks++; if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL b2b_stall1 got %b exp 0", PCWrite); end
        step(); sc_exp = sc_exp + 4'd1;
        n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL b2b_rel1 got %b exp 1", PCWrite); end
        step();
        n_checks++; if ({EX_MemRead, EX_Rt} !== {1'b1, 5'd11}) begin n_fail++; $display("FAIL b2b_ld2 got %h exp %h", {EX_MemRead, EX_Rt}, {1'b1, 5'd11}); end
        @(negedge Clk); drive(5'd2, 5'd11, 5'd12, 1'b1, 1'b0, 4'h2, 32'h0);
        #1;
        n_checks++; if (PCWrite !== 1'b0) begin n_fail++; $display("FAIL b2b_stall2 got %b exp 0", PCWrite); end
        step(); sc_exp = sc_exp + 4'd1;
        n_checks++; if (StallCount !== sc_exp) begin n_fail++; $display("FAIL b2b_cnt got %0d exp %0d", StallCount, sc_exp); end
    endtask

    task automatic test_same_rs_rt();
        @(negedge Clk); drive(5'd1, 5'd12, 5'd0, 1'b1, 1'b1, 4'h0, 32'h0);
        step();
        @(negedge Clk); drive(5'd12, 5'd12, 5'd13, 1'b1, 1'b0, 4'h2, 32'h0);
        step(); sc_exp = sc_exp + 4'd1;
        n_checks++; if (PCWrite !== 1'b1) begin n_fail++; $display("FAIL same_rel got %b exp 1", PCWrite); end
        step();
        n_checks++; if (StallCount !== sc_exp) begin n_fail++; $display("FAIL same_cnt got %0d exp %0d", StallCount, sc_exp); end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge Clk); drive(5'd1, 5'd13, 5'd0, 1'b1, 1'b1, 4'h0, 32'h0);
        step();
        @(negedge Clk); drive(5'd13, 5'd2, 5'd3, 1'b1, 1'b0, 4'h4, 32'h0);
        #1; Rst_n = 1'b0; #1; sc_exp = '0;
        n_checks++; if ({EX_MemRead, EX_Rt, StallCount} !== 10'd0) begin n_fail++; $display("FAIL mid_rst got %h exp 0", {EX_MemRead, EX_Rt, StallCount}); end
        n_checks++; if ({PCWrite, IFIDWrite} !== 2'b11) begin n_fail++; $display("FAIL mid_rst_pcw got %b exp 11", {PCWrite, IFIDWrite}); end
        @(negedge Clk); Rst_n = 1'b1;
        step();
        n_checks++; if ({EX_Rs, EX_ALUOp, StallCount} !== {5'd13, 4'h4, 4'd0}) begin n_fail++; $display("FAIL mid_after got %h exp %h", {EX_Rs, EX_ALUOp, StallCount}, {5'd13, 4'h4, 4'd0}); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk); drive(5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 4'h0, 32'h0);
            step();
            @(negedge Clk); drive(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 4'h2, 32'h0);
            step();
            if (sc_exp != 4'hF) sc_exp = sc_exp + 4'd1;
            if (i == 14) begin
                n_checks++; if (StallCount !== 4'hF) begin n_fail++; $display("FAIL sat_reach got %h exp f", StallCount); end
            end
        end
        n_checks++; if (StallCount !== sc_exp) begin n_fail++; $display("FAIL sat_hold got %h exp %h", StallCount, sc_exp); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_reg_zero();
        test_flush();
        test_non_load();
        test_back_to_back();
        test_same_rs_rt();
        test_reset_mid_stall();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core. Each cycle it captures decoded operands, register numbers and control bits from ID and presents them to EX and to the forwarding unit (Rs/Rt comparison inputs). When an EX-stage load targets a register the ID instruction reads, it stalls PC and IF/ID for one cycle and inserts a bubble. It also inserts a bubble on a branch flush and counts stall cycles.

## Interface
- DATA_W, 32, datapath width
- CNT_W, 16, stall counter width
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- Flush  in  1  branch taken in ID; squash the instruction entering EX
- ID_Rs, ID_Rt, ID_Rd  in  5 each  register numbers of the instruction in ID
- ID_ReadData1, ID_ReadData2, ID_SignExt  in  DATA_W each  operand values
- ID_RegWrite, ID_MemToReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst  in  1 each  control bits
- ID_ALUOp  in  4  ALU operation
- EX_Rs, EX_Rt, EX_Rd  out  5 each  registered register numbers (EX_Rs/EX_Rt feed the forwarding unit)
- EX_ReadData1, EX_ReadData2, EX_SignExt  out  DATA_W each  registered operands
- EX_RegWrite, EX_MemToReg, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_RegDst  out  1 each  registered control
- EX_ALUOp  out  4  registered ALU op
- PCWrite  out  1  combinational; 0 holds the PC
- IFIDWrite  out  1  combinational; 0 holds IF/ID
- StallCount  out  CNT_W  stall cycles since reset, saturating

## Operation
- Hazard = EX_MemRead & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | (EX_Rt == ID_Rt)).
- Stall = Hazard & ~Flush. PCWrite = IFIDWrite = ~Stall.
- Bubble = Hazard | Flush.
- On each rising Clk edge without Bubble: all EX_* registers load their ID_* counterparts.
- With Bubble: the seven control outputs (including all 4 EX_ALUOp bits) and EX_Rs, EX_Rt, EX_Rd load 0. Data registers EX_ReadData1/2 and EX_SignExt still load the ID values, which are don't-care downstream.
- A bubble has zero register numbers and RegWrite=0, so the forwarding unit never matches it.
- Flush has priority over Hazard. The PC must take the branch target, so Stall is suppressed. A bubble is still inserted.
- StallCount increments by 1 on each edge where Stall=1 and saturates at all-ones (2^CNT_W-1).

## Timing
- Reset (Rst_n=0, async): every registered output is 0, including StallCount.
  - EX_MemRead=0 therefore PCWrite=IFIDWrite=1 during and after reset.
  - Deassertion is sampled synchronously by the design flow; the first capture is on the first rising edge with Rst_n=1.
- Latency: ID inputs appear at EX outputs exactly 1 cycle later.
- PCWrite/IFIDWrite are combinational from EX_* registers, ID_Rs/ID_Rt and Flush, with no clock latency.
- A load-use stall lasts exactly 1 cycle:
  - the bubble clears EX_MemRead on the next edge;
  - the held ID instruction then enters EX normally.
- Back-to-back loads with a dependency on each: each produces its own single-cycle stall.
- Reset mid-stall: outputs clear immediately, and no stall persists after release.
- ID_Rs=ID_Rt=EX_Rt: a single stall, counted once.

## Test plan
- Reset: drive ID inputs to nonzero values with Rst_n=0 → all EX_* outputs 0, StallCount=0, PCWrite=IFIDWrite=1. Release, then apply ID_Rs=3, ID_ReadData1=32'hDEADBEEF → next cycle EX_Rs=3, EX_ReadData1=32'hDEADBEEF.
- Load-use: lw writing Rt=5 in EX (EX_MemRead=1, EX_Rt=5); ID_Rs=5.
  - Required: PCWrite=0 and IFIDWrite=0 that cycle.
  - Next edge: EX_RegWrite=0, EX_MemRead=0, EX_Rs=EX_Rt=EX_Rd=0, StallCount=1.
  - Following cycle: PCWrite=1 and the held instruction is captured.
- Register-zero: EX_MemRead=1, EX_Rt=0, ID_Rs=0 → no stall, PCWrite=1, StallCount unchanged.
- Flush priority: load-use condition present plus Flush=1 → PCWrite=1, bubble inserted, StallCount unchanged.
- Non-load dependency: EX_MemRead=0, EX_RegWrite=1, EX_Rt=7, ID_Rt=7 → no stall; normal capture.
- Saturation: with CNT_W=4, run 20 consecutive load-use stalls → StallCount reaches 4'hF and holds there.
